// File: rtl/uart_pkg.sv
// Shared constants for the parameterised UART receiver: parity modes and the
// receive FSM state encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push while full is only accepted
// when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: majority-vote bit sampling, optional parity,
// 1/2 stop bits, break/framing detection and a small receive FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HM1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_H    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_HP1  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [3:0]    C_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    C_SLAST = 4'(STOP_BITS - 1);

    rx_state_t            r_state;
    logic                 r_sync1, r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_idx;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_perr, r_any1, r_stop_err;
    logic                 r_push, r_ferr, r_brk, r_overrun;
    logic [DATA_BITS:0]   r_push_data;
    logic                 w_rx_s, w_maj, w_any1_f, w_stop_bad_f;
    logic                 w_pop, w_empty, w_full;
    logic [DATA_BITS:0]   w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_rx_s       = r_sync2;
    assign w_maj        = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_any1_f     = r_any1 | w_maj;
    assign w_stop_bad_f = r_stop_err | ~w_maj;

    // Consumer handshake: the head entry transfers on every cycle where
    // m_valid and m_ready are both high; m_data/m_perr hold until then.
    assign w_pop     = m_valid & m_ready;
    assign m_valid   = ~w_empty;
    assign m_data    = w_head[DATA_BITS-1:0];
    assign m_perr    = w_head[DATA_BITS];
    assign frame_err = r_ferr;
    assign break_det = r_brk;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_perr      <= 1'b0;
            r_any1      <= 1'b0;
            r_stop_err  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_ferr      <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_ferr <= 1'b0;
            r_brk  <= 1'b0;
            case (r_state)
                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
                    if (r_cnt == C_HM1) r_s0 <= w_rx_s;
                    if (r_cnt == C_H)   r_s1 <= w_rx_s;
                    if (r_cnt == C_HP1) begin
                        case (r_state)
                            ST_START: if (w_maj) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                            end
                            ST_DATA: begin
                                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                                r_par   <= r_par ^ w_maj;
                                r_any1  <= r_any1 | w_maj;
                            end
                            ST_PARITY: begin
                                r_perr <= (PARITY == PAR_ODD) ? ~(r_par ^ w_maj) : (r_par ^ w_maj);
                                r_any1 <= r_any1 | w_maj;
                            end
                            default: begin
                                if (r_idx == C_SLAST) begin
                                    // Last stop bit resolved: the frame ends here, mid-bit.
                                    r_cnt <= '0;
                                    if (!w_any1_f) begin
                                        r_brk   <= 1'b1;
                                        r_state <= ST_WAIT_IDLE;
                                    end else if (w_stop_bad_f) begin
                                        r_ferr  <= 1'b1;
                                        r_state <= ST_WAIT_IDLE;
                                    end else begin
                                        r_push      <= 1'b1;
                                        r_push_data <= {r_perr, r_shift};
                                        r_state     <= ST_IDLE;
                                    end
                                end else begin
                                    r_stop_err <= r_stop_err | ~w_maj;
                                    r_any1     <= r_any1 | w_maj;
                                end
                            end
                        endcase
                    end
                    if (r_cnt == C_LAST) begin
                        case (r_state)
                            ST_START: begin
                                r_state <= ST_DATA;
                                r_idx   <= '0;
                            end
                            ST_DATA: begin
                                if (r_idx == C_DLAST) begin
                                    r_idx   <= '0;
                                    r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                                end else begin
                                    r_idx <= r_idx + 1'b1;
                                end
                            end
                            ST_PARITY: begin
                                r_state <= ST_STOP;
                                r_idx   <= '0;
                            end
                            default: r_idx <= r_idx + 1'b1;
                        endcase
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!w_rx_s) begin
                        r_state    <= ST_START;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_par      <= 1'b0;
                        r_perr     <= 1'b0;
                        r_any1     <= 1'b0;
                        r_stop_err <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_overrun <= 1'b0;
        else        r_overrun <= r_push & w_full & ~w_pop;
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clocks per bit period (legal range 8..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-004 The block SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, minimum 2).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port i_rx, input, 1 bit, asynchronous serial line that idles high.
REQ-009 The block SHALL have port m_data, output, DATA_BITS bits, the data at the FIFO head.
REQ-010 The block SHALL have port m_perr, output, 1 bit, the parity-error flag of the head entry.
REQ-011 The block SHALL have port m_valid, output, 1 bit, asserted when the FIFO is not empty.
REQ-012 The block SHALL have port m_ready, input, 1 bit, consumer accept; the head is popped on any cycle where m_valid and m_ready are both high.
REQ-013 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse when a stop bit is sampled 0 on a frame that is not a break.
REQ-014 The block SHALL have port break_det, output, 1 bit, a one-cycle pulse on a break frame.
REQ-015 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when a frame is dropped because the FIFO is full.
REQ-016 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-017 The block SHALL pass i_rx through a 2-flop synchroniser (both flops reset to 1); rx_s denotes the synchronised line.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-019 In IDLE, rx_s=0 SHALL move the FSM to START with the bit counter cleared to 0.
REQ-020 Every bit SHALL be sampled as the 2-of-3 majority of rx_s at counter values H-1, H and H+1, where H=CLKS_PER_BIT/2; the bit value is resolved at counter=H+1.
REQ-021 In START, a majority of 1 SHALL be treated as a glitch: return to IDLE, with no push and no pulse.
REQ-022 Data bits SHALL be received LSB first; after DATA_BITS bits the FSM goes to PARITY if PARITY is not 0, otherwise to STOP.
REQ-023 The parity check SHALL require an odd (PARITY=1) or even (PARITY=2) count of ones over data plus parity bit; a mismatch sets the entry's perr flag.
REQ-024 In STOP, each of the STOP_BITS stop bits SHALL be sampled; the frame completes at the resolve point of the last stop bit.
REQ-025 A frame with every sampled data, parity and stop bit equal to 0 SHALL be a break: pulse break_det, no push, go to WAIT_IDLE.
REQ-026 A non-break frame with any stop bit 0 SHALL pulse frame_err, push nothing, and go to WAIT_IDLE.
REQ-027 A good frame SHALL push {perr, data} and return to IDLE.
REQ-028 WAIT_IDLE SHALL go to IDLE once rx_s has been 1 for CLKS_PER_BIT consecutive cycles.
REQ-029 A push while the FIFO is full and no pop occurs in the same cycle SHALL drop the frame, pulse overrun, and leave the FIFO unchanged.
REQ-030 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; no overrun is raised in that case.
REQ-031 m_valid SHALL rise exactly 1 cycle after the push cycle.
REQ-032 The data of a pushed frame SHALL NOT change while it is held at the FIFO head.
REQ-033 The FIFO pointers SHALL wrap modulo FIFO_DEPTH and the occupancy count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-034 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL reset to 0 at every bit boundary.

Reset
REQ-035 While rst_n=0 the block SHALL hold FSM=IDLE, counters=0, FIFO empty, m_valid=0, m_data=0, m_perr=0, frame_err=0, break_det=0, overrun=0, busy=0, and synchroniser flops=1.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; after release, a new frame is received only after rx_s is seen high and then falls.

Structure
REQ-037 Shared package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state encoding.
REQ-038 The FIFO SHALL be a sub-module uart_rx_fifo (synchronous, first-word-fall-through, with count output).

Verification (CLKS_PER_BIT=16 unless stated)
REQ-039 Byte 0xA5, 8N1 -> m_valid high with m_data=0xA5 and m_perr=0; no error pulses.
REQ-040 PARITY=2, 0x03 sent with parity bit 1 -> entry 0x03 with m_perr=1.
REQ-041 A low pulse of 4 clocks on the idle line -> no push, busy returns to 0, no pulse.
REQ-042 Stop bit driven 0 on 0x55 -> frame_err pulses once, FIFO unchanged; line held low for 12 bit times -> break_det pulses once, then recovery after line high.
REQ-043 FIFO_DEPTH=4, m_ready=0, five bytes 0x01..0x05 -> overrun pulses on the fifth; draining yields 0x01..0x04 in order.
REQ-044 FIFO full with m_ready=1 in the push cycle of a new byte -> no overrun, and the count stays 4.
